// File: rtl/uvmt_cv32e40s_obi_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : uvmt_cv32e40s_obi_responder_if
// Purpose  : OBI address/response bundle between a core-side master and the
//            memory-side responder.
// Revision : 1.0
// ============================================================================
interface uvmt_cv32e40s_obi_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/uvmt_cv32e40s_obi_responder.sv
`default_nettype none
// ============================================================================
// Module   : uvmt_cv32e40s_obi_responder
// Purpose  : OBI memory-side responder: LFSR-driven bounded grant stalls,
//            in-order responses with bounded latency, small word memory.
//            Define UVMT_OBI_RSP_ERR_EN to enable the error address window.
// Revision : 1.0
// ============================================================================
module uvmt_cv32e40s_obi_responder #(
  parameter int unsigned MEM_WORDS       = 16,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_GNT_STALLS  = 4,
  parameter int unsigned MAX_RSP_STALLS  = 8,
  parameter logic [15:0] SEED            = 16'hACE1,
  parameter logic [31:0] ERR_ADDR_LO     = 32'hFFFF_0000,
  parameter logic [31:0] ERR_ADDR_HI     = 32'hFFFF_FFFF
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_ni,
  input  wire logic                     stall_en_i,
  uvmt_cv32e40s_obi_responder_if.slave  obi
);

  localparam int unsigned c_IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned c_AGE_MAX = MAX_RSP_STALLS + 1;
  localparam int unsigned c_AGE_W   = $clog2(c_AGE_MAX + 1);
  localparam int unsigned c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned c_SCNT_W  = $clog2(MAX_GNT_STALLS + 1);
  localparam logic [15:0] c_SEED    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] c_TAPS    = 16'hB400;

  logic [15:0]                r_lfsr;
  logic                       r_stall;
  logic [c_SCNT_W-1:0]        r_stall_cnt;
  logic [c_SCNT_W-1:0]        w_stall_cnt_n;
  logic [c_CNT_W-1:0]         r_cnt;
  logic                       r_retire;
  logic [31:0]                r_mem [MEM_WORDS];

  logic [MAX_OUTSTANDING-1:0] r_vld;
  logic [MAX_OUTSTANDING-1:0] r_er;
  logic [31:0]                r_dat [MAX_OUTSTANDING];
  logic [c_AGE_W-1:0]         r_age [MAX_OUTSTANDING];
  logic [c_AGE_W-1:0]         r_tgt [MAX_OUTSTANDING];

  logic [MAX_OUTSTANDING-1:0] w_n_vld;
  logic [MAX_OUTSTANDING-1:0] w_n_er;
  logic [31:0]                w_n_dat [MAX_OUTSTANDING];
  logic [c_AGE_W-1:0]         w_n_age [MAX_OUTSTANDING];
  logic [c_AGE_W-1:0]         w_n_tgt [MAX_OUTSTANDING];
  logic                       w_placed;
  logic                       w_n_rsp;

  logic                       r_rvalid;
  logic [31:0]                r_rdata;
  logic                       r_err;

  logic                       w_full;
  logic                       w_gnt;
  logic                       w_acc;
  logic                       w_err_hit;
  logic [c_IDX_W-1:0]         w_idx;
  logic [31:0]                w_rsp_data;
  logic [31:0]                w_rnd;
  logic [c_AGE_W-1:0]         w_tgt;

  assign w_full = (r_cnt == c_CNT_W'(MAX_OUTSTANDING));
  assign w_gnt  = obi.req & ~w_full & ~r_stall;
  assign w_acc  = obi.req & w_gnt;
  assign w_idx  = obi.addr[2 +: c_IDX_W];

`ifdef UVMT_OBI_RSP_ERR_EN
  assign w_err_hit = (obi.addr >= ERR_ADDR_LO) && (obi.addr <= ERR_ADDR_HI);
`else
  assign w_err_hit = 1'b0;
`endif

  // Reads sample memory at acceptance, so later writes never alter them.
  assign w_rsp_data = (obi.we || w_err_hit) ? 32'h0 : r_mem[w_idx];
  assign w_rnd      = {28'h0, r_lfsr[3:0]};
  assign w_tgt      = stall_en_i ? c_AGE_W'((w_rnd % c_AGE_MAX) + 1) : c_AGE_W'(1);

  always_comb begin
    if (!obi.req || w_gnt) begin
      w_stall_cnt_n = '0;
    end else if (!w_full && (r_stall_cnt != c_SCNT_W'(MAX_GNT_STALLS))) begin
      w_stall_cnt_n = r_stall_cnt + c_SCNT_W'(1);
    end else begin
      w_stall_cnt_n = r_stall_cnt;
    end
  end

  // Next FIFO image: retire head, age everyone, append the accepted entry.
  always_comb begin
    w_n_vld  = r_vld;
    w_n_er   = r_er;
    w_n_dat  = r_dat;
    w_n_age  = r_age;
    w_n_tgt  = r_tgt;
    w_placed = 1'b0;
    if (r_rvalid) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
        w_n_vld[i] = r_vld[i+1];
        w_n_er[i]  = r_er[i+1];
        w_n_dat[i] = r_dat[i+1];
        w_n_age[i] = r_age[i+1];
        w_n_tgt[i] = r_tgt[i+1];
      end
      w_n_vld[MAX_OUTSTANDING-1] = 1'b0;
    end
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (w_n_vld[i] && (w_n_age[i] != c_AGE_W'(c_AGE_MAX))) begin
        w_n_age[i] = w_n_age[i] + c_AGE_W'(1);
      end
    end
    // A new entry has already lived through its acceptance cycle.
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (w_acc && !w_placed && !w_n_vld[i]) begin
        w_n_vld[i] = 1'b1;
        w_n_er[i]  = w_err_hit;
        w_n_dat[i] = w_rsp_data;
        w_n_age[i] = c_AGE_W'(1);
        w_n_tgt[i] = w_tgt;
        w_placed   = 1'b1;
      end
    end
    w_n_rsp = w_n_vld[0] && (w_n_age[0] >= w_n_tgt[0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr      <= c_SEED;
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
      r_cnt       <= '0;
      r_retire    <= 1'b0;
      r_vld       <= '0;
      r_er        <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        r_dat[i] <= '0;
        r_age[i] <= '0;
        r_tgt[i] <= '0;
      end
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        r_mem[i] <= '0;
      end
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_lfsr      <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
      r_stall_cnt <= w_stall_cnt_n;
      // Look at the updated run length so a run never exceeds MAX_GNT_STALLS.
      r_stall     <= stall_en_i & r_lfsr[15] & r_lfsr[14] &
                     (w_stall_cnt_n < c_SCNT_W'(MAX_GNT_STALLS));
      // A slot is released one cycle after its response, never in that cycle.
      r_retire    <= r_rvalid;
      r_cnt       <= r_cnt + c_CNT_W'(w_acc) - c_CNT_W'(r_retire);
      r_vld       <= w_n_vld;
      r_er        <= w_n_er;
      r_dat       <= w_n_dat;
      r_age       <= w_n_age;
      r_tgt       <= w_n_tgt;
      if (w_acc && obi.we && !w_err_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (obi.be[b]) begin
            r_mem[w_idx][8*b +: 8] <= obi.wdata[8*b +: 8];
          end
        end
      end
      r_rvalid    <= w_n_rsp;
      r_rdata     <= w_n_rsp ? w_n_dat[0] : 32'h0;
      r_err       <= w_n_rsp & w_n_er[0];
    end
  end

  assign obi.gnt    = w_gnt;
  assign obi.rvalid = r_rvalid;
  assign obi.rdata  = r_rdata;
  assign obi.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_cv32e40s_obi_responder.sv
`default_nettype none
// Bench for uvmt_cv32e40s_obi_responder: directed transactions plus a random
// stalled phase, all responses checked against a scoreboard and memory model.
module tb_uvmt_cv32e40s_obi_responder;
  localparam int MEM_WORDS = 16;
  localparam int MAX_OUT   = 2;
  localparam int MAX_GNT   = 4;
  localparam int MAX_RSP   = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
    bit          nostall;
  } exp_t;

  logic clk_i      = 1'b0;
  logic rst_ni     = 1'b0;
  logic stall_en_i = 1'b0;

  uvmt_cv32e40s_obi_responder_if bus();

  uvmt_cv32e40s_obi_responder #(
    .MEM_WORDS       (MEM_WORDS),
    .MAX_OUTSTANDING (MAX_OUT),
    .MAX_GNT_STALLS  (MAX_GNT),
    .MAX_RSP_STALLS  (MAX_RSP),
    .SEED            (16'hACE1),
    .ERR_ADDR_LO     (32'hFFFF_0000),
    .ERR_ADDR_HI     (32'hFFFF_FFFF)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .stall_en_i (stall_en_i),
    .obi        (bus)
  );

  always #5 clk_i = ~clk_i;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  exp_t        sb[$];
  logic [31:0] m_mem [MEM_WORDS];
  int          slots, rv_prev, run, max_run, n_gnt, n_rv;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin : mon
    exp_t e;
    int   lat;
    bit   full;
    bit   err;
    logic [3:0] idx;
    if (!rst_ni) begin
      sb.delete();
      for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
      slots = 0; rv_prev = 0; run = 0; n_gnt = 0; n_rv = 0;
    end else begin
      if (bus.rvalid) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          e   = sb.pop_front();
          lat = cyc - e.gcyc;
          chk("rsp_rdata", bus.rdata, e.rdata);
          chk("rsp_err", {31'h0, bus.err}, {31'h0, e.err});
          chk("rsp_latency_bound", {31'h0, (lat >= 1 && lat <= MAX_RSP + 1)}, 32'd1);
          if (e.nostall) chk("rsp_latency_nostall", lat, 32'd1);
        end
        n_rv++;
        last_rdata = bus.rdata;
        last_err   = bus.err;
      end else begin
        chk("idle_outputs", bus.rdata | {31'h0, bus.err}, 32'h0);
      end
      full = (slots >= MAX_OUT);
      if (bus.req && !bus.gnt && !full) begin
        run++;
        if (run > max_run) max_run = run;
      end else if (!bus.req || bus.gnt) begin
        run = 0;
      end
      if (bus.req && bus.gnt) begin
        idx = bus.addr[5:2];
`ifdef UVMT_OBI_RSP_ERR_EN
        err = (bus.addr >= 32'hFFFF_0000);
`else
        err = 1'b0;
`endif
        e.rdata   = (bus.we || err) ? 32'h0 : m_mem[idx];
        e.err     = err;
        e.gcyc    = cyc;
        e.nostall = !stall_en_i;
        if (bus.we && !err) begin
          for (int b = 0; b < 4; b++)
            if (bus.be[b]) m_mem[idx][8*b +: 8] = bus.wdata[8*b +: 8];
        end
        sb.push_back(e);
        n_gnt++;
      end
      slots   = slots + int'(bus.req && bus.gnt) - rv_prev;
      rv_prev = int'(bus.rvalid);
    end
  end

  task automatic obi_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, output int waited);
    bit got = 1'b0;
    waited     = 0;
    last_rdata = 'x;
    last_err   = 1'bx;
    bus.req = 1'b1; bus.addr = a; bus.we = w; bus.be = b; bus.wdata = d;
    while (!got && waited < 64) begin
      @(negedge clk_i);
      got = bus.gnt;
      waited++;
      @(posedge clk_i); #1;
    end
    bus.req = 1'b0;
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, k;
    logic        g;
    logic [4:0]  gpat;
    logic [31:0] r;
    bit          pend;

    bus.req = 1'b0; bus.addr = '0; bus.we = 1'b0; bus.be = '0; bus.wdata = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_gnt", {31'h0, bus.gnt}, 32'd0);
    chk("reset_rvalid", {31'h0, bus.rvalid}, 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_err", {31'h0, bus.err}, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    obi_txn(32'h0, 1'b0, 4'hF, 32'h0, n);
    chk("rd0_gnt_same_cycle", n, 32'd1);
    wait_idle();
    chk("rd0_rdata", last_rdata, 32'h0);

    obi_txn(32'h4, 1'b1, 4'b0011, 32'hDEAD_BEEF, n);
    wait_idle();
    chk("wr_rsp_rdata", last_rdata, 32'h0);
    obi_txn(32'h4, 1'b0, 4'hF, 32'h0, n);
    wait_idle();
    chk("rd_be_merge", last_rdata, 32'h0000_BEEF);

    // Four back-to-back reads with req held: slots fill at two outstanding.
    gpat = 5'b11011;
    k = 0;
    bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      g = bus.gnt;
      chk($sformatf("b2b_gnt_c%0d", c), {31'h0, g}, {31'h0, gpat[4-c]});
      if (g) k++;
      @(posedge clk_i); #1;
      if (k >= 4) bus.req = 1'b0;
      else bus.addr = 32'(k * 4);
    end
    bus.req = 1'b0;
    wait_idle();

    stall_en_i = 1'b1;
    max_run = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk_i);
      pend = bus.req && !bus.gnt;
      @(posedge clk_i); #1;
      if (!pend) begin
        r = $urandom();
        bus.req   = (r[1:0] != 2'b00);
        bus.we    = r[2];
        bus.be    = r[6:3];
        bus.addr  = {(r[9:8] == 2'b00) ? 16'hFFFF : 16'h0000, 6'h0, r[17:10], 2'b00};
        bus.wdata = $urandom();
      end
    end
    bus.req = 1'b0;
    wait_idle();
    chk("quiesce_rvalid_eq_gnt", n_rv, n_gnt);
    chk("stall_run_max", {31'h0, (max_run <= MAX_GNT)}, 32'd1);

    // Reset with requests in flight: nothing may respond afterwards.
    k = 0; n = 0;
    bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = 32'h8;
    while (k < 2 && n < 64) begin
      @(negedge clk_i);
      if (bus.gnt) k++;
      n++;
      @(posedge clk_i); #1;
    end
    chk("rst_setup_gnts", k, 32'd2);
    bus.req = 1'b0;
    rst_ni  = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (15) @(posedge clk_i);
    #1;
    chk("rst_discard_rvalid", n_rv, 32'd0);
    stall_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    obi_txn(32'h4, 1'b0, 4'hF, 32'h0, n);
    wait_idle();
    chk("rst_mem_cleared", last_rdata, 32'h0);

`ifdef UVMT_OBI_RSP_ERR_EN
    obi_txn(32'hFFFF_0000, 1'b1, 4'hF, 32'h1234_5678, n);
    wait_idle();
    chk("err_wr_err", {31'h0, last_err}, 32'd1);
    obi_txn(32'hFFFF_0000, 1'b0, 4'hF, 32'h0, n);
    wait_idle();
    chk("err_rd_err", {31'h0, last_err}, 32'd1);
    chk("err_rd_rdata", last_rdata, 32'h0);
    obi_txn(32'h0, 1'b0, 4'hF, 32'h0, n);
    wait_idle();
    chk("err_rd0_noerr", {31'h0, last_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
